poly_select_engine: RTL and testbench
=====================================

POLY_SELECT_ENGINE -- requirements
Module: poly_select_engine

Interface
REQ-001 SHALL provide parameter OUT_W, default 16, number of output lanes (bits) per beat.
REQ-002 SHALL provide parameter POOL_W, default 2560, width of the concatenated polynomial-state pool.
REQ-003 SHALL provide parameter CODE_W, default 5, selection-code width; tap-table depth is 2**CODE_W entries.
REQ-004 SHALL derive AW = ceil(log2(POOL_W)) and LW = ceil(log2(OUT_W)) internally; neither is overridable.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-009 in_pool  in  POOL_W  concatenated polynomial states for this beat.
REQ-010 in_code  in  CODE_W  selection code for this beat.
REQ-011 out_valid  out  1  data_out valid.
REQ-012 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-013 data_out  out  OUT_W  selected tap bits.
REQ-014 out_code  out  CODE_W  code used for the beat in data_out.
REQ-015 cfg_we  in  1  tap-table write strobe.
REQ-016 cfg_code  in  CODE_W  table entry written.
REQ-017 cfg_lane  in  LW  lane within entry written.
REQ-018 cfg_addr  in  AW  pool bit index stored for that lane.
REQ-019 busy  out  1  high while table initialisation runs.

Function
REQ-020 SHALL hold a tap table of 2**CODE_W entries x OUT_W lanes x AW bits.
REQ-021 FSM states INIT and RUN; INIT entered on reset, RUN entered after last entry written; RUN never returns to INIT except by rst.
REQ-022 INIT SHALL write one entry per cycle, entry k lane i = (k*OUT_W + i) mod POOL_W, k = 0..2**CODE_W-1, taking exactly 2**CODE_W cycles; busy = 1 throughout, 0 in RUN.
REQ-023 in_ready SHALL be 0 in INIT; cfg_we SHALL be ignored in INIT.
REQ-024 Two-stage pipeline: stage A registers in_pool/in_code on accept; stage B registers data_out[i] = pool_A[table[code_A][i]] and out_code = code_A.
REQ-025 Latency: beat accepted in cycle N SHALL appear on out_valid in cycle N+2 when out_ready stays high; throughput one beat per cycle.
REQ-026 in_ready = RUN && (stage A empty || stage A advancing); stage A advances when stage B empty or out_ready high.
REQ-027 When out_valid && !out_ready, data_out, out_code, out_valid SHALL hold stable; no beat lost or duplicated.
REQ-028 Table lookup SHALL use contents as of the cycle stage A advances; a cfg write in that same cycle SHALL take effect from the following cycle only.
REQ-029 cfg writes with cfg_addr >= POOL_W or cfg_lane >= OUT_W SHALL be ignored.

Reset
REQ-030 On rst: state INIT, table-init counter 0, stage A/B valid 0, out_valid 0, data_out 0, out_code 0, in_ready 0, busy 1 next cycle.
REQ-031 rst mid-operation SHALL discard in-flight beats and all cfg writes; table re-initialised to REQ-022 defaults.

Configuration
REQ-032 Macro POLY_SEL_PARITY_EN: when defined, SHALL add output parity_out (1 bit) = XOR of data_out, registered with and held alongside data_out, reset 0; when undefined, port and logic absent, all else identical.

Verification
REQ-033 rst 1 cycle, OUT_W=16, CODE_W=5 -> busy high exactly 32 cycles, in_ready 0 throughout, then in_ready 1.
REQ-034 After init, in_pool = 1<<37, in_code=2 -> data_out = 0x0020 (lane 5 taps bit 37) two cycles after accept, out_code=2.
REQ-035 cfg write code 3 lane 15 addr 0, then in_pool=1, in_code=3 -> data_out = 0x8000.
REQ-036 Continuous beats, out_ready low 5 cycles mid-stream -> data_out stable during stall, output sequence matches input order, no gaps after release.
REQ-037 cfg write to code 4 in same cycle code-4 beat leaves stage A -> that beat uses old tap, next code-4 beat uses new tap.
REQ-038 With POLY_SEL_PARITY_EN, data_out=0x0007 -> parity_out=1; rst during stall -> out_valid 0 next cycle, busy 1.

Source files
------------

// File: rtl/poly_select_engine.sv
// Programmable tap selector: picks OUT_W bits from a wide polynomial-state pool through a
// per-code tap table, in a two-stage valid/ready pipeline. Define POLY_SEL_PARITY_EN for parity_out.
module poly_select_engine #(
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned POOL_W = 2560,
   parameter int unsigned CODE_W = 5,
   localparam int unsigned AW    = $clog2(POOL_W),
   localparam int unsigned LW    = $clog2(OUT_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [POOL_W-1:0] in_pool,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  data_out,
   output logic [CODE_W-1:0] out_code,
   input  logic              cfg_we,
   input  logic [CODE_W-1:0] cfg_code,
   input  logic [LW-1:0]     cfg_lane,
   input  logic [AW-1:0]     cfg_addr,
   output logic              busy
`ifdef POLY_SEL_PARITY_EN
   ,
   output logic              parity_out
`endif
);

   localparam int unsigned Entries = 2 ** CODE_W;

   typedef enum logic {StInit, StRun} state_e;

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   init_cnt_q, init_cnt_d;
   logic [AW-1:0]       tap_q [Entries][OUT_W];
   logic [AW-1:0]       init_tap [OUT_W];

   logic                a_valid_q;
   logic [POOL_W-1:0]   a_pool_q;
   logic [CODE_W-1:0]   a_code_q;
   logic                b_valid_q;
   logic [OUT_W-1:0]    data_q;
   logic [CODE_W-1:0]   code_q;

   logic [OUT_W-1:0]    lookup;
   logic                a_adv;
   logic                accept;
   logic                cfg_ok;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == StInit) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == CODE_W'(Entries - 1)) begin
            state_d = StRun;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // Default tap layout: entry k covers pool bits k*OUT_W .. k*OUT_W+OUT_W-1, wrapped.
   always_comb begin
      for (int unsigned i = 0; i < OUT_W; i++) begin
         init_tap[i] = AW'((32'(init_cnt_q) * OUT_W + i) % POOL_W);
      end
   end

   // Out-of-range lanes/addresses are dropped so every stored tap indexes a real pool bit.
   assign cfg_ok = cfg_we && !rst && (state_q == StRun)
                   && ({1'b0, cfg_lane} < (LW + 1)'(OUT_W))
                   && ({1'b0, cfg_addr} < (AW + 1)'(POOL_W));

   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         for (int unsigned i = 0; i < OUT_W; i++) begin
            tap_q[init_cnt_q][i] <= init_tap[i];
         end
      end else if (cfg_ok) begin
         tap_q[cfg_code][cfg_lane] <= cfg_addr;
      end
   end

   always_comb begin
      lookup = '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         lookup[i] = a_pool_q[tap_q[a_code_q][i]];
      end
   end

   assign a_adv    = !b_valid_q || out_ready;
   assign in_ready = (state_q == StRun) && (!a_valid_q || a_adv);
   assign accept   = in_valid && in_ready;

`ifdef POLY_SEL_PARITY_EN
   logic parity_q;
   assign parity_out = parity_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         data_q    <= '0;
         code_q    <= '0;
`ifdef POLY_SEL_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         if (in_ready) begin
            a_valid_q <= in_valid;
         end
         if (a_adv) begin
            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
               data_q <= lookup;
               code_q <= a_code_q;
`ifdef POLY_SEL_PARITY_EN
               parity_q <= ^lookup;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_pool_q <= in_pool;
         a_code_q <= in_code;
      end
   end

   assign out_valid = b_valid_q;
   assign data_out  = data_q;
   assign out_code  = code_q;
   assign busy      = (state_q == StInit);

endmodule

// File: tb/tb_poly_select_engine.sv
// Scoreboard bench for poly_select_engine: a tap-table model predicts each accepted beat and a
// monitor pops/compares on every output handshake. Define POLY_SEL_PARITY_EN to cover parity_out.
module tb_poly_select_engine;

   localparam int OUT_W   = 16;
   localparam int POOL_W  = 2560;
   localparam int CODE_W  = 5;
   localparam int AW      = 12;
   localparam int LW      = 4;
   localparam int ENTRIES = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [POOL_W-1:0] in_pool = '0;
   logic [CODE_W-1:0] in_code = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [OUT_W-1:0]  data_out;
   logic [CODE_W-1:0] out_code;
   logic              cfg_we = 1'b0;
   logic [CODE_W-1:0] cfg_code = '0;
   logic [LW-1:0]     cfg_lane = '0;
   logic [AW-1:0]     cfg_addr = '0;
   logic              busy;
`ifdef POLY_SEL_PARITY_EN
   logic              parity_out;
`endif

   poly_select_engine #(
      .OUT_W  (OUT_W),
      .POOL_W (POOL_W),
      .CODE_W (CODE_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pool   (in_pool),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_code  (out_code),
      .cfg_we    (cfg_we),
      .cfg_code  (cfg_code),
      .cfg_lane  (cfg_lane),
      .cfg_addr  (cfg_addr),
      .busy      (busy)
`ifdef POLY_SEL_PARITY_EN
      ,
      .parity_out(parity_out)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int model_tap [ENTRIES][OUT_W];

   typedef struct {
      logic [OUT_W-1:0]  data;
      logic [CODE_W-1:0] code;
   } exp_t;
   exp_t sbq[$];
   int   hs_cycles[$];

   bit rnd_mode  = 1'b0;
   bit ready_val = 1'b1;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_val;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_init();
      for (int k = 0; k < ENTRIES; k++)
         for (int i = 0; i < OUT_W; i++)
            model_tap[k][i] = (k * OUT_W + i) % POOL_W;
   endfunction

   function automatic logic [OUT_W-1:0] model_sel(input logic [POOL_W-1:0] pool,
                                                  input logic [CODE_W-1:0] code);
      logic [OUT_W-1:0] d;
      for (int i = 0; i < OUT_W; i++) d[i] = pool[model_tap[code][i]];
      return d;
   endfunction

   function automatic logic [POOL_W-1:0] rand_pool();
      logic [POOL_W-1:0] p;
      for (int w = 0; w < POOL_W / 32; w++) p[w*32 +: 32] = $urandom();
      return p;
   endfunction

   // Monitor: compare on handshake, and hold-stability across stall cycles.
   logic [OUT_W-1:0]  hold_data;
   logic [CODE_W-1:0] hold_code;
   bit                stalled = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", data_out, hold_data);
            check("stall_code", out_code, hold_code);
         end
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            hs_cycles.push_back(cyc);
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data %0h code %0d expected none", data_out,
                        out_code);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("beat_data", data_out, e.data);
               check("beat_code", out_code, e.code);
`ifdef POLY_SEL_PARITY_EN
               check("beat_parity", parity_out, ^e.data);
`endif
            end
         end else if (out_valid) begin
            stalled   = 1'b1;
            hold_data = data_out;
            hold_code = out_code;
         end
      end
   end

   task automatic send(input logic [POOL_W-1:0] pool, input logic [CODE_W-1:0] code);
      int n = 0;
      in_valid = 1'b1;
      in_pool  = pool;
      in_code  = code;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
            break;
         end
      end
      if (in_ready) begin
         exp_t e;
         e.data = model_sel(pool, code);
         e.code = code;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input int code, input int lane, input int addr);
      cfg_we   = 1'b1;
      cfg_code = CODE_W'(code);
      cfg_lane = LW'(lane);
      cfg_addr = AW'(addr);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      if (addr < POOL_W && lane < OUT_W) model_tap[code][lane] = addr;
   endtask

   task automatic drain();
      int n = 0;
      rnd_mode  = 1'b0;
      ready_val = 1'b1;
      while ((sbq.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset_and_init();
      int n = 0;
      int rdy_bad = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sbq.delete();
      model_init();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_out_code", out_code, 0);
      check("rst_busy", busy, 1);
      while (busy && n < 200) begin
         if (in_ready) rdy_bad++;
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, 32);
      check("ready_during_init", rdy_bad, 0);
      check("ready_after_init", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [POOL_W-1:0] p;
      int hs0;

      #1;
      do_reset_and_init();

      // Default tap: code 2 lane 5 reads pool bit 37; visible two cycles after accept.
      p = '0;
      p[37] = 1'b1;
      send(p, 2);
      @(negedge clk);
      check("lat_n1_valid", out_valid, 0);
      @(negedge clk);
      check("lat_n2_valid", out_valid, 1);
      check("lat_n2_data", data_out, 16'h0020);
      check("lat_n2_code", out_code, 2);
      drain();

      // Reprogram code 3 lane 15 to pool bit 0.
      cfg_write(3, 15, 0);
      p = '0;
      p[0] = 1'b1;
      send(p, 3);
      @(negedge clk);
      @(negedge clk);
      check("cfg_data", data_out, 16'h8000);
      drain();

      // Out-of-range address must be ignored (code 6 lane 0 stays on bit 96).
      cfg_write(6, 0, 3000);
      p = '0;
      p[96] = 1'b1;
      send(p, 6);
      drain();

      // cfg write in the same cycle a code-4 beat leaves stage A.
      p = '0;
      p[100] = 1'b1;
      send(p, 4);
      cfg_we   = 1'b1;
      cfg_code = 5'd4;
      cfg_lane = 4'd0;
      cfg_addr = 12'd100;
      model_tap[4][0] = 100;
      send(p, 4);
      cfg_we = 1'b0;
      drain();

      // Continuous stream with a 5-cycle downstream stall in the middle.
      hs0 = hs_cycles.size();
      fork
         begin
            for (int b = 0; b < 20; b++) send(rand_pool(), CODE_W'($urandom_range(0, 31)));
         end
         begin
            repeat (8) @(posedge clk);
            ready_val = 1'b0;
            repeat (5) @(posedge clk);
            ready_val = 1'b1;
         end
      join
      drain();
      check("stream_beats", hs_cycles.size() - hs0, 20);
      if (hs_cycles.size() >= hs0 + 20)
         check("stream_span", hs_cycles[hs0 + 19] - hs_cycles[hs0], 24);

      // Randomized traffic with random backpressure and periodic reconfiguration.
      for (int r = 0; r < 4; r++) begin
         rnd_mode = 1'b1;
         for (int b = 0; b < 40; b++) begin
            send(rand_pool(), CODE_W'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
         drain();
         for (int c = 0; c < 4; c++)
            cfg_write($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 4095));
      end

      // Reset while a beat is stalled at the output; table writes must be discarded.
      ready_val = 1'b0;
      p = '0;
      p[2:0] = 3'b111;
      send(p, 0);
      @(negedge clk);
      @(negedge clk);
      check("stall_pre_rst_valid", out_valid, 1);
      check("stall_pre_rst_data", data_out, 16'h0007);
`ifdef POLY_SEL_PARITY_EN
      check("parity_0007", parity_out, 1);
`endif
      @(posedge clk);
      #1;
      ready_val = 1'b1;
      do_reset_and_init();
      p = '0;
      p[0] = 1'b1;
      send(p, 3);
      @(negedge clk);
      @(negedge clk);
      check("post_rst_default_tap", data_out, 16'h0000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
